bcd_seg_display: RTL and testbench
==================================

# bcd_seg_display

Parametrised binary-to-seven-segment display controller. Takes a WIDTH-bit binary value and converts it to DIGITS decimal digits with an iterative shift-and-add-3 (double-dabble) engine. It adds signed display, leading-zero blanking, overflow indication and a load/busy/done handshake. It sits between the CPU write-data path and the board HEX displays, and replaces per-digit divide/modulo logic with a multi-cycle sequential converter.

## Interface
- WIDTH, 16, binary input width (≥ 4)
- DIGITS, 4, number of seven-segment digits driven (1–8)
- ACTIVE_LOW, 1, 1 = a lit segment drives 0 (board HEX polarity)
- BLANK_LZ, 1, 1 = blank leading zeros; digit 0 is always shown
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- load  in  1  request a conversion of `data`; accepted only when `busy`=0
- data  in  WIDTH  value to display, sampled on the accepting edge
- signed_mode  in  1  sampled with `data`; 1 = treat `data` as two's complement
- disp_en  in  1  0 = all segments dark; 1 = show the held value
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when `seg` has been updated
- overflow  out  1  held: last value did not fit in DIGITS
- neg  out  1  held: last value was displayed as negative
- seg  out  7*DIGITS  digit i occupies seg[7i+6:7i] = {g,f,e,d,c,b,a}; digit 0 is the least significant

## Operation
- FSM states:
  - IDLE: load=1 → capture, go to CONV.
  - CONV: runs for exactly WIDTH cycles, then goes to FMT.
  - FMT: runs for 1 cycle, then returns to IDLE.
- Capture: if signed_mode & data[WIDTH-1], mag = (~data+1) as unsigned WIDTH bits and neg_next=1; otherwise mag = data and neg_next=0. The most negative value (e.g. -32768) maps to magnitude 32768.
- CONV: each cycle, every BCD nibble ≥ 5 gets +3, then {bcd, mag} shifts left by 1. The BCD register is 4*DIGITS bits. A 1 shifted out of the top nibble sets a sticky ovf_next.
- FMT:
  - Find msd = index of the highest nonzero digit (0 if the value is 0).
  - If neg_next and msd = DIGITS-1, set ovf_next. The sign needs a free digit; for DIGITS=1 any negative value overflows.
  - Overflow: every digit shows '-' (segment g only), and neg=0.
  - Otherwise:
    - Digits ≤ msd show their decimal glyph.
    - Digits above msd are blank (BLANK_LZ=1) or show '0' (BLANK_LZ=0).
    - If negative, digit msd+1 shows '-'.
- Glyphs (a..g lit):
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg
  - 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg
  - '-' g, blank none
- Polarity: ACTIVE_LOW inverts all 7*DIGITS bits at the output.
- disp_en=0 forces all segments dark. The held display register is preserved, and disp_en=1 restores it.
- The display register keeps the previous value throughout CONV, so no flicker or partial values are shown.
- load while busy=1 is ignored; there is no queue and no error flag.

## Timing
- Reset values:
  - busy=0, done=0, overflow=0, neg=0.
  - seg = all dark (all 1s if ACTIVE_LOW).
  - FSM in IDLE; display register cleared to blank.
- rst mid-conversion aborts immediately: the same reset values apply and there is no done pulse.
- Edge E0 samples load=1 in IDLE. busy is high from after E0 through the FMT cycle.
- At edge E0+WIDTH+1 (end of FMT):
  - seg, overflow and neg update together.
  - done is high for the following cycle only.
  - busy returns to 0 on that same edge.
- Latency is WIDTH+1 edges after capture (17 for WIDTH=16). A new load can be accepted in the same cycle done is high.
- Simultaneous rst and load: rst wins.
- disp_en is registered: seg reflects a disp_en change one edge later.

## Test plan
All scenarios use the default parameters (WIDTH=16, DIGITS=4, ACTIVE_LOW=1, BLANK_LZ=1).
- Unsigned 1234, signed_mode=0: done exactly 17 edges after load. seg = {1111001, 0100100, 0110000, 0011001} (digit3..0); overflow=0, neg=0.
- Value 7: digits 3..1 = 1111111 and digit0 = 1111000. Value 0: digit0 = 1000000 and the rest blank.
- Signed 0xFFD6 (-42): digits = {1111111, 0111111, 0011001, 0100100}, neg=1.
  - Signed -999 shows "-999".
  - Signed -1000 gives overflow=1, all digits 0111111.
- Unsigned 12345: overflow=1, every digit 0111111. Then loading 5 clears overflow and shows digit0 = 0010010.
- Load 1234 then pulse load with 9999 at busy cycle 5: the second load is ignored, and exactly one done pulse shows 1234. Toggling disp_en 1→0→1 blanks seg, then restores 1234.
- Assert rst at CONV cycle 8 of a conversion: the next edge gives busy=0, seg all 1s and no done pulse. A subsequent load of 42 then completes normally.

Source files
------------

// File: rtl/bcd_seg_display.sv
// Binary-to-seven-segment display controller. A multi-cycle double-dabble engine converts a
// WIDTH-bit value into DIGITS BCD digits. The result is then formatted into segment glyphs
// with sign, leading-zero blanking and overflow indication.
module bcd_seg_display #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned BLANK_LZ   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      data,
  input  logic                  signed_mode,
  input  logic                  disp_en,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  neg,
  output logic [7*DIGITS-1:0]   seg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GlyphDash  = 7'b1000000;
  localparam logic [6:0] GlyphBlank = 7'b0000000;

  typedef enum logic [1:0] {StIdle, StConv, StFmt} state_e;

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [BcdW-1:0]       bcd_q, bcd_d;
  logic [BcdW-1:0]       bcd_adj;
  logic                  ovf_q, ovf_d;
  logic                  sign_q, sign_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7*DIGITS-1:0]   disp_q, disp_d;
  logic                  overflow_q, overflow_d;
  logic                  neg_q, neg_d;
  logic                  done_q, done_d;
  logic                  en_q;
  logic                  fmt_ovf;
  logic [7*DIGITS-1:0]   fmt_disp;
  logic [7*DIGITS-1:0]   lit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b0111111;
      4'd1:    glyph = 7'b0000110;
      4'd2:    glyph = 7'b1011011;
      4'd3:    glyph = 7'b1001111;
      4'd4:    glyph = 7'b1100110;
      4'd5:    glyph = 7'b1101101;
      4'd6:    glyph = 7'b1111101;
      4'd7:    glyph = 7'b0000111;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1101111;
      default: glyph = GlyphBlank;
    endcase
  endfunction

  // Add-3 correction on every nibble that is 5 or more, ahead of the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Format the finished BCD value into glyphs; a negative value needs a spare digit for '-'
  always_comb begin
    int unsigned msd;
    msd = 0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    fmt_ovf  = ovf_q | (sign_q & (msd == DIGITS - 1));
    fmt_disp = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (fmt_ovf) begin
        fmt_disp[7*i +: 7] = GlyphDash;
      end else if (i <= msd) begin
        fmt_disp[7*i +: 7] = glyph(bcd_q[4*i +: 4]);
      end else if (sign_q && (i == msd + 1)) begin
        fmt_disp[7*i +: 7] = GlyphDash;
      end else if (BLANK_LZ != 0) begin
        fmt_disp[7*i +: 7] = GlyphBlank;
      end else begin
        fmt_disp[7*i +: 7] = glyph(4'd0);
      end
    end
  end

  // Next-state logic for the capture / convert / format sequence
  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    sign_d     = sign_q;
    cnt_d      = cnt_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          sign_d  = signed_mode & data[WIDTH-1];
          mag_d   = sign_d ? (~data + WIDTH'(1)) : data;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = StConv;
        end
      end
      StConv: begin
        {bcd_d, mag_d} = {bcd_adj[BcdW-2:0], mag_q, 1'b0};
        // A carry out of the top nibble means the value needs more digits than we have
        ovf_d = ovf_q | bcd_adj[BcdW-1];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFmt;
      end
      StFmt: begin
        disp_d     = fmt_disp;
        overflow_d = fmt_ovf;
        neg_d      = sign_q & ~fmt_ovf;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mag_q      <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
      cnt_q      <= '0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      sign_q     <= sign_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
      en_q       <= disp_en;
    end
  end

  // Output gating and board polarity
  always_comb begin
    lit = en_q ? disp_q : '0;
    seg = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign neg      = neg_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed self-checking bench for bcd_seg_display at default parameters.
module tb_bcd_seg_display;

  // Active-low glyphs {g,f,e,d,c,b,a}
  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] D  = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic        signed_mode;
  logic        disp_en;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        neg;
  logic [27:0] seg;

  int n_cmp  = 0;
  int n_fail = 0;

  bcd_seg_display dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .data        (data),
    .signed_mode (signed_mode),
    .disp_en     (disp_en),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .neg         (neg),
    .seg         (seg)
  );

  always #5 clk = ~clk;

  // Issue one load and wait (bounded) for done; busy must hold high until done appears
  task automatic convert(input logic [15:0] val, input logic sm, output int lat,
                         output logic busy_ok);
    data        = val;
    signed_mode = sm;
    load        = 1'b1;
    @(posedge clk); #1;
    load    = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data = '0; signed_mode = 1'b0; disp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %b want 0", neg); end
    n_cmp++; if (seg !== {B, B, B, B}) begin n_fail++; $display("FAIL reset_seg got %h want %h", seg, {B, B, B, B}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_1234();
    int lat; logic bok;
    convert(16'd1234, 1'b0, lat, bok);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL u1234_latency got %0d want 17", lat); end
    n_cmp++; if (bok !== 1'b1) begin n_fail++; $display("FAIL u1234_busy got %b want 1", bok); end
    n_cmp++; if (seg !== {G1, G2, G3, G4}) begin n_fail++; $display("FAIL u1234_seg got %h want %h", seg, {G1, G2, G3, G4}); end
    n_cmp++; if ({overflow, neg} !== 2'b00) begin n_fail++; $display("FAIL u1234_flags got %b want 00", {overflow, neg}); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL u1234_done_pulse got %b want 0", done); end
  endtask

  task automatic test_small_values();
    int lat; logic bok;
    convert(16'd7, 1'b0, lat, bok);
    n_cmp++; if (seg !== {B, B, B, G7}) begin n_fail++; $display("FAIL v7_seg got %h want %h", seg, {B, B, B, G7}); end
    convert(16'd0, 1'b0, lat, bok);
    n_cmp++; if (seg !== {B, B, B, G0}) begin n_fail++; $display("FAIL v0_seg got %h want %h", seg, {B, B, B, G0}); end
    convert(16'd9999, 1'b0, lat, bok);
    n_cmp++; if (seg !== {G9, G9, G9, G9} || overflow !== 1'b0) begin
      n_fail++; $display("FAIL v9999 got seg %h ovf %b want %h ovf 0", seg, overflow, {G9, G9, G9, G9});
    end
  endtask

  task automatic test_signed();
    int lat; logic bok;
    convert(16'hFFD6, 1'b1, lat, bok);
    n_cmp++; if (seg !== {B, D, G4, G2}) begin n_fail++; $display("FAIL s42_seg got %h want %h", seg, {B, D, G4, G2}); end
    n_cmp++; if ({overflow, neg} !== 2'b01) begin n_fail++; $display("FAIL s42_flags got %b want 01", {overflow, neg}); end
    convert(16'hFC19, 1'b1, lat, bok);
    n_cmp++; if (seg !== {D, G9, G9, G9}) begin n_fail++; $display("FAIL s999_seg got %h want %h", seg, {D, G9, G9, G9}); end
    n_cmp++; if ({overflow, neg} !== 2'b01) begin n_fail++; $display("FAIL s999_flags got %b want 01", {overflow, neg}); end
    convert(16'hFC18, 1'b1, lat, bok);
    n_cmp++; if (seg !== {D, D, D, D}) begin n_fail++; $display("FAIL s1000_seg got %h want %h", seg, {D, D, D, D}); end
    n_cmp++; if ({overflow, neg} !== 2'b10) begin n_fail++; $display("FAIL s1000_flags got %b want 10", {overflow, neg}); end
    convert(16'h8000, 1'b1, lat, bok);
    n_cmp++; if ({overflow, neg} !== 2'b10) begin n_fail++; $display("FAIL smin_flags got %b want 10", {overflow, neg}); end
    // Same bit pattern as -42 but unsigned: 65494 does not fit
    convert(16'hFFD6, 1'b0, lat, bok);
    n_cmp++; if ({overflow, neg} !== 2'b10) begin n_fail++; $display("FAIL u65494_flags got %b want 10", {overflow, neg}); end
  endtask

  task automatic test_overflow();
    int lat; logic bok;
    convert(16'd12345, 1'b0, lat, bok);
    n_cmp++; if (seg !== {D, D, D, D}) begin n_fail++; $display("FAIL u12345_seg got %h want %h", seg, {D, D, D, D}); end
    n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL u12345_ovf got %b want 1", overflow); end
    // Load accepted in the same cycle done is high
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", done); end
    convert(16'd5, 1'b0, lat, bok);
    n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_latency got %0d want 17", lat); end
    n_cmp++; if (seg !== {B, B, B, G5} || overflow !== 1'b0) begin
      n_fail++; $display("FAIL v5 got seg %h ovf %b want %h ovf 0", seg, overflow, {B, B, B, G5});
    end
  endtask

  task automatic test_ignored_load();
    int dones;
    data = 16'd1234; signed_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    dones = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 5) begin data = 16'd9999; load = 1'b1; end
      else load = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
    end
    load = 1'b0;
    n_cmp++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", dones); end
    n_cmp++; if (seg !== {G1, G2, G3, G4}) begin n_fail++; $display("FAIL ign_seg got %h want %h", seg, {G1, G2, G3, G4}); end
    disp_en = 1'b0;
    #1;
    n_cmp++; if (seg !== {G1, G2, G3, G4}) begin n_fail++; $display("FAIL en_reg_delay got %h want %h", seg, {G1, G2, G3, G4}); end
    @(posedge clk); #1;
    n_cmp++; if (seg !== {B, B, B, B}) begin n_fail++; $display("FAIL en_off got %h want %h", seg, {B, B, B, B}); end
    disp_en = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (seg !== {G1, G2, G3, G4}) begin n_fail++; $display("FAIL en_on got %h want %h", seg, {G1, G2, G3, G4}); end
  endtask

  task automatic test_reset_abort();
    int dones; int lat; logic bok;
    data = 16'd1234; signed_mode = 1'b0; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if (seg !== {B, B, B, B}) begin n_fail++; $display("FAIL abort_seg got %h want %h", seg, {B, B, B, B}); end
    n_cmp++; if ({done, overflow, neg} !== 3'b000) begin n_fail++; $display("FAIL abort_flags got %b want 000", {done, overflow, neg}); end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", dones); end
    convert(16'd42, 1'b0, lat, bok);
    n_cmp++; if (lat !== 17 || bok !== 1'b1) begin n_fail++; $display("FAIL post_abort_lat got %0d busy %b want 17 busy 1", lat, bok); end
    n_cmp++; if (seg !== {B, B, G4, G2}) begin n_fail++; $display("FAIL post_abort_seg got %h want %h", seg, {B, B, G4, G2}); end
  endtask

  initial begin
    test_reset();
    test_unsigned_1234();
    test_small_values();
    test_signed();
    test_overflow();
    test_ignored_load();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
